display_scheduler: RTL and testbench

Sequencer for the display multiplexer that chooses between the 10-bit frequency and current readings. It drives the mux select line, alternating automatically on a dwell timer or stepping manually from a debounced pushbutton. At every switch or refresh it captures a stable snapshot of the selected value. The snapshot is offered to the downstream BCD/7-segment stage over a valid/ready handshake, so the display never shows a value that changes mid-conversion.

---
 rtl/display_pkg.sv | 16 +
 rtl/display_scheduler_debounce.sv | 51 +++++
 rtl/display_scheduler.sv | 137 +++++++++++++
 tb/tb_display_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants and FSM state type for the display scheduler.
// Holds the default word width, timer defaults and the IDLE/CAPTURE/OFFER enum.
package display_pkg;

  localparam int W_DEF       = 10;
  localparam int DWELL_DEF   = 50_000_000;
  localparam int REFRESH_DEF = 5_000_000;
  localparam int DEB_DEF     = 500_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    OFFER   = 2'd2
  } state_t;

endpackage

// File: rtl/display_scheduler_debounce.sv
// debounce_pulse: 2-FF synchroniser, stability counter and rising-edge pulse.
// Ports: clk, reset (async high), btn_i (raw button), pulse_o (1-cycle press).
module debounce_pulse
  import display_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          lvl_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // cnt_q counts prior differing samples; this one makes DEB_CYCLES
  assign accept = (sync2_q != lvl_q) &&
                  (cnt_q == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= accept && sync2_q;
      if (sync2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= '0;
        lvl_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: alternates the frequency/current mux and offers snapshots.
// Ports: clk, reset, modo_auto, boton, frecuencia, corriente, dato_listo in;
//        selector, dato, dato_valido out (valid/ready toward BCD stage).
module display_scheduler
  import display_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int DWELL      = DWELL_DEF,
  parameter int REFRESH    = REFRESH_DEF,
  parameter int DEB_CYCLES = DEB_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         modo_auto,
  input  logic         boton,
  input  logic [W-1:0] frecuencia,
  input  logic [W-1:0] corriente,
  output logic         selector,
  output logic [W-1:0] dato,
  output logic         dato_valido,
  input  logic         dato_listo
);

  localparam int DW = $clog2(DWELL);
  localparam int RW = $clog2(REFRESH);

  logic          btn_pulse;
  logic          modo_q;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;
  logic [RW-1:0] ref_q;
  logic [RW-1:0] ref_d;
  logic          pend_tog_q;
  logic          pend_tog_d;
  logic          pend_ref_q;
  logic          pend_ref_d;
  state_t        state_q;
  logic          sel_q;
  logic [W-1:0]  dato_q;
  logic          valid_q;

  logic mode_chg;
  logic dwell_tick;
  logic ref_tick;
  logic idle;
  logic start;
  logic tog_evt;

  debounce_pulse #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (boton),
    .pulse_o(btn_pulse)
  );

  assign mode_chg   = modo_auto ^ modo_q;
  assign dwell_tick = modo_auto && !mode_chg &&
                      (dwell_q == DW'(DWELL - 1));
  assign ref_tick   = (ref_q == RW'(REFRESH - 1));
  assign idle       = (state_q == IDLE);
  assign start      = idle && (pend_tog_q || pend_ref_q);
  // a button press and a dwell tick on the same edge are two events
  assign tog_evt    = btn_pulse ^ dwell_tick;

  always_comb begin
    dwell_d = dwell_q + 1'b1;
    if (!modo_auto || mode_chg || btn_pulse || dwell_tick)
      dwell_d = '0;
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    if (start || ref_tick)
      ref_d = '0;
  end

  // service clears first, then the new event flips the flag
  always_comb begin
    pend_tog_d = (pend_tog_q && !idle) ^ tog_evt;
    pend_ref_d = start ? 1'b0 : (pend_ref_q || ref_tick);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      modo_q     <= 1'b0;
      dwell_q    <= '0;
      ref_q      <= '0;
      pend_tog_q <= 1'b0;
      pend_ref_q <= 1'b1;
    end else begin
      modo_q     <= modo_auto;
      dwell_q    <= dwell_d;
      ref_q      <= ref_d;
      pend_tog_q <= pend_tog_d;
      pend_ref_q <= pend_ref_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      dato_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_tog_q) begin
            sel_q   <= ~sel_q;
            state_q <= CAPTURE;
          end else if (pend_ref_q) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          dato_q  <= sel_q ? frecuencia : corriente;
          valid_q <= 1'b1;
          state_q <= OFFER;
        end
        OFFER: begin
          if (dato_listo) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign selector    = sel_q;
  assign dato        = dato_q;
  assign dato_valido = valid_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed tests of display_scheduler with short timers.
// DWELL=8, REFRESH=20, DEB_CYCLES=4; drives and samples on the falling edge.
module tb_display_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       modo_auto;
  logic       boton;
  logic [9:0] frecuencia;
  logic [9:0] corriente;
  logic       selector;
  logic [9:0] dato;
  logic       dato_valido;
  logic       dato_listo;

  int checks = 0;
  int errors = 0;
  logic sel_m;

  display_scheduler #(
    .W         (10),
    .DWELL     (8),
    .REFRESH   (20),
    .DEB_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .modo_auto  (modo_auto),
    .boton      (boton),
    .frecuencia (frecuencia),
    .corriente  (corriente),
    .selector   (selector),
    .dato       (dato),
    .dato_valido(dato_valido),
    .dato_listo (dato_listo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic wait_toggle(input int budget, output int n,
                             output bit got);
    logic s0;
    s0 = selector;
    n = 0;
    while (selector === s0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    got = (selector !== s0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    modo_auto = 1'b0;
    boton = 1'b0;
    dato_listo = 1'b1;
    corriente = 10'h155;
    frecuencia = 10'h2AA;
    sel_m = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (selector !== 1'b0) begin
      errors++;
      $display("FAIL rst_sel got %b want 0", selector);
    end
    checks++;
    if (dato !== 10'h000) begin
      errors++;
      $display("FAIL rst_dato got %h want 000", dato);
    end
    checks++;
    if (dato_valido !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", dato_valido);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b0) begin
      errors++;
      $display("FAIL first_cap_early got %b want 0", dato_valido);
    end
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b1 || dato !== 10'h155 || selector !== 1'b0) begin
      errors++;
      $display("FAIL first_cap got v=%b d=%h s=%b want v=1 d=155 s=0",
               dato_valido, dato, selector);
    end
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b0) begin
      errors++;
      $display("FAIL first_xfer got %b want 0", dato_valido);
    end
  endtask

  task automatic test_auto;
    int n;
    bit got;
    frecuencia = 10'd300;
    corriente = 10'd120;
    dato_listo = 1'b1;
    modo_auto = 1'b1;
    wait_toggle(30, n, got);
    sel_m = ~sel_m;
    checks++;
    if (!got || selector !== sel_m) begin
      errors++;
      $display("FAIL auto_first got s=%b after %0d want s=%b", selector,
               n, sel_m);
    end
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checks++;
      if (dato_valido !== 1'b1 || dato !== (sel_m ? 10'd300 : 10'd120))
      begin
        errors++;
        $display("FAIL auto_val%0d got v=%b d=%0d want v=1 d=%0d", r,
                 dato_valido, dato, sel_m ? 300 : 120);
      end
      @(negedge clk);
      checks++;
      if (dato_valido !== 1'b0) begin
        errors++;
        $display("FAIL auto_pulse%0d got v=%b want 0", r, dato_valido);
      end
      if (r < 3) begin
        wait_toggle(30, n, got);
        sel_m = ~sel_m;
        checks++;
        if (!got || n + 2 != 8 || selector !== sel_m) begin
          errors++;
          $display("FAIL auto_period%0d got %0d cycles s=%b want 8 s=%b",
                   r, n + 2, selector, sel_m);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit got;
    logic [9:0] exp;
    wait_toggle(30, n, got);
    sel_m = ~sel_m;
    checks++;
    if (!got || n != 6 || selector !== sel_m) begin
      errors++;
      $display("FAIL bp_toggle got n=%0d s=%b want n=6 s=%b", n,
               selector, sel_m);
    end
    dato_listo = 1'b0;
    exp = sel_m ? 10'd300 : 10'd120;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      checks++;
      if (dato_valido !== 1'b1 || dato !== exp || selector !== sel_m) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%0d s=%b want v=1 d=%0d s=%b",
                 i, dato_valido, dato, selector, exp, sel_m);
      end
    end
    dato_listo = 1'b1;
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b0 || selector !== sel_m) begin
      errors++;
      $display("FAIL bp_xfer got v=%b s=%b want v=0 s=%b", dato_valido,
               selector, sel_m);
    end
    @(negedge clk);
    sel_m = ~sel_m;
    checks++;
    if (selector !== sel_m) begin
      errors++;
      $display("FAIL bp_flip got s=%b want %b", selector, sel_m);
    end
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b1 || dato !== (sel_m ? 10'd300 : 10'd120)) begin
      errors++;
      $display("FAIL bp_new got v=%b d=%0d want v=1 d=%0d", dato_valido,
               dato, sel_m ? 300 : 120);
    end
    modo_auto = 1'b0;
    repeat (10) @(negedge clk);
    sel_m = ~sel_m;
    checks++;
    if (selector !== sel_m || dato_valido !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got s=%b v=%b want s=%b v=0", selector,
               dato_valido, sel_m);
    end
  endtask

  task automatic test_debounce;
    bit   pat [6];
    int   tg;
    logic prev;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tg = 0;
    prev = selector;
    for (int i = 0; i < 24; i++) begin
      boton = (i < 6) ? pat[i] : 1'b1;
      @(negedge clk);
      if (selector !== prev) tg++;
      prev = selector;
    end
    sel_m = ~sel_m;
    checks++;
    if (tg != 1 || selector !== sel_m) begin
      errors++;
      $display("FAIL deb_press got %0d toggles s=%b want 1 s=%b", tg,
               selector, sel_m);
    end
    checks++;
    if (dato !== (sel_m ? 10'd300 : 10'd120)) begin
      errors++;
      $display("FAIL deb_dato got %0d want %0d", dato,
               sel_m ? 300 : 120);
    end
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tg = 0;
    prev = selector;
    for (int i = 0; i < 20; i++) begin
      boton = (i < 6) ? pat[i] : 1'b0;
      @(negedge clk);
      if (selector !== prev) tg++;
      prev = selector;
    end
    checks++;
    if (tg != 0 || selector !== sel_m) begin
      errors++;
      $display("FAIL deb_release got %0d toggles s=%b want 0 s=%b", tg,
               selector, sel_m);
    end
  endtask

  task automatic test_cancel;
    int n;
    bit got;
    modo_auto = 1'b1;
    dato_listo = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_toggle(30, n, got);
      sel_m = ~sel_m;
      checks++;
      if (!got || selector !== sel_m) begin
        errors++;
        $display("FAIL cancel_sync%0d got s=%b want %b", t, selector,
                 sel_m);
      end
    end
    dato_listo = 1'b0;
    @(negedge clk);
    boton = 1'b1;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if (dato_valido !== 1'b1 || selector !== sel_m) begin
        errors++;
        $display("FAIL cancel_hold%0d got v=%b s=%b want v=1 s=%b", i,
                 dato_valido, selector, sel_m);
      end
    end
    dato_listo = 1'b1;
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b0 || selector !== sel_m) begin
      errors++;
      $display("FAIL cancel_xfer got v=%b s=%b want v=0 s=%b",
               dato_valido, selector, sel_m);
    end
    for (int i = 14; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (selector !== sel_m) begin
        errors++;
        $display("FAIL cancel_after%0d got s=%b want %b", i, selector,
                 sel_m);
      end
    end
    boton = 1'b0;
    modo_auto = 1'b0;
    repeat (12) @(negedge clk);
    sel_m = ~sel_m;
    checks++;
    if (selector !== sel_m) begin
      errors++;
      $display("FAIL cancel_drain got s=%b want %b", selector, sel_m);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    dato_listo = 1'b0;
    corriente = 10'h0AB;
    n = 0;
    while (dato_valido !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dato_valido !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait got v=%b after %0d want 1", dato_valido, n);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dato_valido !== 1'b0 || selector !== 1'b0 || dato !== 10'h000)
    begin
      errors++;
      $display("FAIL mid_async got v=%b s=%b d=%h want 0 0 000",
               dato_valido, selector, dato);
    end
    @(negedge clk);
    reset = 1'b0;
    dato_listo = 1'b1;
    sel_m = 1'b0;
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b0) begin
      errors++;
      $display("FAIL mid_early got v=%b want 0", dato_valido);
    end
    @(negedge clk);
    checks++;
    if (dato_valido !== 1'b1 || dato !== 10'h0AB || selector !== sel_m)
    begin
      errors++;
      $display("FAIL mid_recap got v=%b d=%h s=%b want v=1 d=0ab s=0",
               dato_valido, dato, selector);
    end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_backpressure();
    test_debounce();
    test_cancel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
